// File: rtl/ct_spsram_gen2_pkg.sv
// ct_spsram_gen2_pkg
//   Shared definitions for the parametrised single-port SRAM wrapper:
//   - init sweep FSM state encoding
//   - helper that derives the write-mask group width G = DATA_WIDTH / WE_WIDTH
package ct_spsram_gen2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_DONE  = 2'b10
  } init_state_e;

  // Data bits covered by one WEN bit. DATA_WIDTH must be a multiple of WE_WIDTH.
  function automatic int grp_width(input int data_width, input int we_width);
    return data_width / we_width;
  endfunction

endpackage

// File: rtl/ct_spsram_gen2_if.sv
// ct_spsram_gen2_if
//   Macro-style access bus of the SRAM wrapper (all enables active low).
//   A    : access address
//   CEN  : chip enable
//   GWEN : global write enable (0 = write, 1 = read)
//   WEN  : per-group write enable
//   D    : write data
//   Q    : read data
//   master = L2C pipeline side, slave = SRAM wrapper side.
interface ct_spsram_gen2_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 128,
  parameter int WE_WIDTH   = 16
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [WE_WIDTH-1:0]   WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;

  modport master (
    output A, CEN, GWEN, WEN, D,
    input  Q
  );

  modport slave (
    input  A, CEN, GWEN, WEN, D,
    output Q
  );
endinterface

// File: rtl/ct_spsram_gen2_init.sv
// ct_spsram_gen2_init
//   Post-reset zero-initialisation sequencer. Sweeps every address once,
//   asserting a write strobe each cycle, then raises init_done for good.
// Ports:
//   forever_cpuclk : clock
//   cpurst_b       : asynchronous active-low reset
//   init_addr_o    : address being cleared
//   init_we_o      : write strobe for the zero write at init_addr_o
//   init_done_o    : array is usable by the user port
module ct_spsram_gen2_init
  import ct_spsram_gen2_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int INIT_EN    = 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  output logic [ADDR_WIDTH-1:0] init_addr_o,
  output logic                  init_we_o,
  output logic                  init_done_o
);

  // Reset lands directly in CLEAR so the first edge after release already
  // clears address 0; the sweep then takes exactly DEPTH cycles.
  localparam init_state_e RESET_STATE = (INIT_EN != 0) ? ST_CLEAR : ST_DONE;
  localparam logic        RESET_DONE  = (INIT_EN == 0);

  init_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  init_we;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      done_q  <= RESET_DONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    init_we = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // Last address is written on this edge; done is visible next cycle.
        if (&cnt_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign init_addr_o = cnt_q;
  assign init_we_o   = init_we;
  assign init_done_o = done_q;

endmodule

// File: rtl/ct_spsram_gen2.sv
// ct_spsram_gen2
//   Parametrised single-port SRAM wrapper for L2C data/tag arrays.
//   Adds configurable write-mask granularity, optional output register,
//   Q hold between reads and a post-reset zero sweep.
// Ports:
//   forever_cpuclk : clock, all state on the rising edge
//   cpurst_b       : asynchronous active-low reset
//   bus            : macro-style access bus (A/CEN/GWEN/WEN/D in, Q out)
//   init_done      : high once the array is usable
module ct_spsram_gen2
  import ct_spsram_gen2_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 128,
  parameter int WE_WIDTH   = 16,
  parameter int OUT_FLOP   = 0,
  parameter int INIT_EN    = 1
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  ct_spsram_gen2_if.slave     bus,
  output logic                init_done
);

  localparam int G     = grp_width(DATA_WIDTH, WE_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_we;
  logic                  init_done_w;

  ct_spsram_gen2_init #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_EN    (INIT_EN)
  ) u_init (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .init_addr_o    (init_addr),
    .init_we_o      (init_we),
    .init_done_o    (init_done_w)
  );

  assign init_done = init_done_w;

  // User port is fully ignored until the sweep has finished.
  logic user_wr;
  logic user_rd;
  assign user_wr = init_done_w & ~bus.CEN & ~bus.GWEN;
  assign user_rd = init_done_w & ~bus.CEN &  bus.GWEN;

  // Init sweep owns the array while it runs; it writes zero to every group.
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WE_WIDTH-1:0]   grp_we;
  logic [DATA_WIDTH-1:0] wr_data;

  assign mem_addr = init_we ? init_addr : bus.A;

  for (genvar gi = 0; gi < WE_WIDTH; gi++) begin : g_grp
    assign grp_we[gi]             = init_we | (user_wr & ~bus.WEN[gi]);
    assign wr_data[gi*G +: G]     = init_we ? '0 : bus.D[gi*G +: G];
  end

  // Storage: per-group write enables, contents not reset.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge forever_cpuclk) begin
    for (int g = 0; g < WE_WIDTH; g++) begin
      if (grp_we[g]) begin
        mem[mem_addr][g*G +: G] <= wr_data[g*G +: G];
      end
    end
  end

  // Read register: loads only on a real read, otherwise holds the last value.
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_data_q <= '0;
    end else if (user_rd) begin
      rd_data_q <= mem[bus.A];
    end
  end

  if (OUT_FLOP != 0) begin : g_out_flop
    logic                  rd_vld_q;
    logic [DATA_WIDTH-1:0] out_q;

    // Second stage follows the first only after a read, keeping hold
    // behaviour identical through both stages.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
        rd_vld_q <= 1'b0;
        out_q    <= '0;
      end else begin
        rd_vld_q <= user_rd;
        if (rd_vld_q) begin
          out_q <= rd_data_q;
        end
      end
    end

    assign bus.Q = out_q;
  end else begin : g_no_out_flop
    assign bus.Q = rd_data_q;
  end

endmodule

// File: tb/tb_ct_spsram_gen2.sv
module tb_ct_spsram_gen2;

  logic clk;
  logic rst_b;
  logic done0, done1;

  int tests_run    = 0;
  int tests_failed = 0;

  ct_spsram_gen2_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WE_WIDTH(4)) bus0 ();
  ct_spsram_gen2_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WE_WIDTH(4)) bus1 ();

  ct_spsram_gen2 #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .WE_WIDTH(4), .OUT_FLOP(0), .INIT_EN(1)
  ) u_dut0 (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .bus            (bus0),
    .init_done      (done0)
  );

  ct_spsram_gen2 #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .WE_WIDTH(4), .OUT_FLOP(1), .INIT_EN(1)
  ) u_dut1 (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .bus            (bus1),
    .init_done      (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: array contents, cycles since reset release, and the
  // expected Q of each variant. Q (latency 1) is the most recent read result;
  // the registered variant shows exactly what the unregistered one showed a
  // cycle earlier.
  logic [31:0] mem_m [16];
  int          init_cnt;
  logic [31:0] q0_exp, q1_exp;

  task automatic step(input logic cen, input logic gwen, input logic [3:0] wen,
                      input logic [3:0] a, input logic [31:0] d);
    bit active;
    bus0.CEN = cen; bus0.GWEN = gwen; bus0.WEN = wen; bus0.A = a; bus0.D = d;
    bus1.CEN = cen; bus1.GWEN = gwen; bus1.WEN = wen; bus1.A = a; bus1.D = d;
    @(posedge clk);
    #1;
    active = (init_cnt >= 16);
    q1_exp = q0_exp;
    if (active && !cen) begin
      if (gwen) q0_exp = mem_m[a];
      else for (int g = 0; g < 4; g++) if (!wen[g]) mem_m[a][g*8 +: 8] = d[g*8 +: 8];
    end
    if (init_cnt < 16) begin
      init_cnt++;
      if (init_cnt == 16) for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 4'hF, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    bus0.CEN = 1'b1; bus0.GWEN = 1'b1; bus0.WEN = 4'hF; bus0.A = '0; bus0.D = '0;
    bus1.CEN = 1'b1; bus1.GWEN = 1'b1; bus1.WEN = 4'hF; bus1.A = '0; bus1.D = '0;
    init_cnt = 0; q0_exp = 32'h0; q1_exp = 32'h0;
    #3;
    tests_run++; if (bus0.Q !== 32'h0) begin tests_failed++; $display("FAIL reset_q0: got %h expected %h", bus0.Q, 32'h0); end
    tests_run++; if (bus1.Q !== 32'h0) begin tests_failed++; $display("FAIL reset_q1: got %h expected %h", bus1.Q, 32'h0); end
    tests_run++; if (done0 !== 1'b0) begin tests_failed++; $display("FAIL reset_done0: got %b expected 0", done0); end
    tests_run++; if (done1 !== 1'b0) begin tests_failed++; $display("FAIL reset_done1: got %b expected 0", done1); end
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_b = 1'b1;
  endtask

  // Sweep timing, with random traffic plus a write to A=3 that must be ignored.
  task automatic test_init();
    logic exp_done;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) step(1'b0, 1'b0, 4'h0, 4'd3, 32'hFFFF_FFFF);
      else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), $urandom);
      exp_done = (init_cnt >= 16);
      tests_run++; if (done0 !== exp_done) begin tests_failed++; $display("FAIL init_done0 cyc %0d: got %b expected %b", k, done0, exp_done); end
      tests_run++; if (done1 !== exp_done) begin tests_failed++; $display("FAIL init_done1 cyc %0d: got %b expected %b", k, done1, exp_done); end
      tests_run++; if (bus0.Q !== q0_exp) begin tests_failed++; $display("FAIL init_q0 cyc %0d: got %h expected %h", k, bus0.Q, q0_exp); end
      tests_run++; if (bus1.Q !== q1_exp) begin tests_failed++; $display("FAIL init_q1 cyc %0d: got %h expected %h", k, bus1.Q, q1_exp); end
    end
    $display("[TB] init sweep: init_done=%b/%b after %0d cycles", done0, done1, init_cnt);
  endtask

  task automatic test_read_all();
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 1'b1, 4'($urandom), 4'(a), $urandom);
      tests_run++; if (bus0.Q !== q0_exp) begin tests_failed++; $display("FAIL readall_q0 a=%0d: got %h expected %h", a, bus0.Q, q0_exp); end
      tests_run++; if (bus1.Q !== q1_exp) begin tests_failed++; $display("FAIL readall_q1 a=%0d: got %h expected %h", a, bus1.Q, q1_exp); end
    end
    step(1'b0, 1'b1, 4'h0, 4'd3, 32'h0);
    tests_run++; if (bus0.Q !== 32'h0) begin tests_failed++; $display("FAIL init_write_ignored_q0: got %h expected %h", bus0.Q, 32'h0); end
    idle();
    tests_run++; if (bus1.Q !== 32'h0) begin tests_failed++; $display("FAIL init_write_ignored_q1: got %h expected %h", bus1.Q, 32'h0); end
    $display("[TB] read all after init: A=3 q0=%h q1=%h", bus0.Q, bus1.Q);
  endtask

  task automatic test_mask();
    step(1'b0, 1'b0, 4'b0000, 4'd5, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 4'b1010, 4'd5, 32'h1122_3344);
    step(1'b0, 1'b1, 4'h0, 4'd5, 32'h0);
    tests_run++; if (bus0.Q !== 32'hDE22_BE44) begin tests_failed++; $display("FAIL mask_q0: got %h expected %h", bus0.Q, 32'hDE22_BE44); end
    idle();
    tests_run++; if (bus1.Q !== 32'hDE22_BE44) begin tests_failed++; $display("FAIL mask_q1: got %h expected %h", bus1.Q, 32'hDE22_BE44); end
    tests_run++; if (bus0.Q !== q0_exp) begin tests_failed++; $display("FAIL mask_model_q0: got %h expected %h", bus0.Q, q0_exp); end
    $display("[TB] masked write A=5: q0=%h q1=%h", bus0.Q, bus1.Q);
  endtask

  task automatic test_hold();
    step(1'b0, 1'b1, 4'h0, 4'd5, 32'h0);
    tests_run++; if (bus0.Q !== 32'hDE22_BE44) begin tests_failed++; $display("FAIL hold_lat_q0: got %h expected %h", bus0.Q, 32'hDE22_BE44); end
    tests_run++; if (bus1.Q !== q1_exp) begin tests_failed++; $display("FAIL hold_lat_q1: got %h expected %h", bus1.Q, q1_exp); end
    for (int k = 0; k < 5; k++) begin
      if (k < 4) idle();
      else step(1'b0, 1'b0, 4'h0, 4'd6, 32'h0BAD_F00D);
      tests_run++; if (bus0.Q !== 32'hDE22_BE44) begin tests_failed++; $display("FAIL hold_q0 cyc %0d: got %h expected %h", k, bus0.Q, 32'hDE22_BE44); end
      tests_run++; if (bus1.Q !== 32'hDE22_BE44) begin tests_failed++; $display("FAIL hold_q1 cyc %0d: got %h expected %h", k, bus1.Q, 32'hDE22_BE44); end
    end
    idle();
    tests_run++; if (bus1.Q !== 32'hDE22_BE44) begin tests_failed++; $display("FAIL hold_after_wr_q1: got %h expected %h", bus1.Q, 32'hDE22_BE44); end
    $display("[TB] hold: q0=%h q1=%h", bus0.Q, bus1.Q);
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b0, 4'h0, 4'd7, 32'hA5A5_A5A5);
    step(1'b0, 1'b1, 4'h0, 4'd7, 32'h0);
    tests_run++; if (bus0.Q !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL b2b_rd7_q0: got %h expected %h", bus0.Q, 32'hA5A5_A5A5); end
    step(1'b0, 1'b1, 4'h0, 4'd5, 32'h0);
    tests_run++; if (bus0.Q !== 32'hDE22_BE44) begin tests_failed++; $display("FAIL b2b_rd5_q0: got %h expected %h", bus0.Q, 32'hDE22_BE44); end
    tests_run++; if (bus1.Q !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL b2b_rd7_q1: got %h expected %h", bus1.Q, 32'hA5A5_A5A5); end
    idle();
    tests_run++; if (bus1.Q !== 32'hDE22_BE44) begin tests_failed++; $display("FAIL b2b_rd5_q1: got %h expected %h", bus1.Q, 32'hDE22_BE44); end
    $display("[TB] back-to-back: q0=%h q1=%h", bus0.Q, bus1.Q);
  endtask

  task automatic test_random();
    int errs_before = tests_failed;
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), $urandom);
      tests_run++; if (bus0.Q !== q0_exp) begin tests_failed++; $display("FAIL rand_q0 step %0d: got %h expected %h", i, bus0.Q, q0_exp); end
      tests_run++; if (bus1.Q !== q1_exp) begin tests_failed++; $display("FAIL rand_q1 step %0d: got %h expected %h", i, bus1.Q, q1_exp); end
    end
    $display("[TB] random traffic: 300 cycles, %0d new errors", tests_failed - errs_before);
  endtask

  task automatic test_reset_mid_sweep();
    logic exp_done;
    for (int a = 0; a < 16; a++) step(1'b0, 1'b0, 4'h0, 4'(a), $urandom | 32'h1);
    step(1'b0, 1'b1, 4'h0, 4'd9, 32'h0);
    idle();
    // Asynchronous clear, checked before any clock edge.
    rst_b = 1'b0;
    #1;
    init_cnt = 0; q0_exp = 32'h0; q1_exp = 32'h0;
    tests_run++; if (bus0.Q !== 32'h0) begin tests_failed++; $display("FAIL rst1_q0: got %h expected %h", bus0.Q, 32'h0); end
    tests_run++; if (bus1.Q !== 32'h0) begin tests_failed++; $display("FAIL rst1_q1: got %h expected %h", bus1.Q, 32'h0); end
    @(posedge clk); @(negedge clk);
    rst_b = 1'b1;
    for (int k = 0; k < 8; k++) idle();
    rst_b = 1'b0;
    #1;
    init_cnt = 0;
    tests_run++; if (done0 !== 1'b0) begin tests_failed++; $display("FAIL rst2_done0: got %b expected 0", done0); end
    tests_run++; if (done1 !== 1'b0) begin tests_failed++; $display("FAIL rst2_done1: got %b expected 0", done1); end
    tests_run++; if (bus1.Q !== 32'h0) begin tests_failed++; $display("FAIL rst2_q1: got %h expected %h", bus1.Q, 32'h0); end
    @(posedge clk); @(negedge clk);
    rst_b = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      idle();
      exp_done = (init_cnt >= 16);
      tests_run++; if (done0 !== exp_done) begin tests_failed++; $display("FAIL resweep_done0 cyc %0d: got %b expected %b", k, done0, exp_done); end
      tests_run++; if (done1 !== exp_done) begin tests_failed++; $display("FAIL resweep_done1 cyc %0d: got %b expected %b", k, done1, exp_done); end
    end
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 1'b1, 4'h0, 4'(a), 32'h0);
      tests_run++; if (bus0.Q !== 32'h0) begin tests_failed++; $display("FAIL resweep_zero_q0 a=%0d: got %h expected %h", a, bus0.Q, 32'h0); end
      tests_run++; if (bus1.Q !== q1_exp) begin tests_failed++; $display("FAIL resweep_zero_q1 a=%0d: got %h expected %h", a, bus1.Q, q1_exp); end
    end
    $display("[TB] reset mid-sweep: init_done=%b/%b, array re-cleared", done0, done1);
  endtask

  initial begin
    test_reset();
    test_init();
    test_read_all();
    test_mask();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
